// File: rtl/shot_responder_if.sv
// Link-side handshake bundle for the shot responder: incoming shot,
// ship-map read port and outgoing result message.
interface shot_responder_if;
    logic       shot_valid;
    logic [7:0] shot_addr;
    logic       shot_ready;
    logic       ship_rd;
    logic [7:0] ship_addr;
    logic       ship_data;
    logic [1:0] msg_out;
    logic       msg_valid;
    logic       msg_ready;

    modport slave (
        input  shot_valid, shot_addr, ship_data, msg_ready,
        output shot_ready, ship_rd, ship_addr, msg_out, msg_valid
    );

    modport master (
        output shot_valid, shot_addr, ship_data, msg_ready,
        input  shot_ready, ship_rd, ship_addr, msg_out, msg_valid
    );
endinterface

// File: rtl/shot_responder.sv
// Defending-side shot responder: classifies an incoming shot against the
// local ship map, tracks hits and remaining ship cells, and returns a
// 2-bit result code over a valid/ready handshake.
module shot_responder #(
    parameter int BOARD_DIM  = 10,
    parameter int SHIP_CELLS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             armed,
    input  logic             new_game,
    shot_responder_if.slave  bus,
    output logic [6:0]       cells_left,
    output logic             game_over
);
    localparam int         CELLS = BOARD_DIM * BOARD_DIM;
    localparam int         IW    = $clog2(CELLS);
    localparam logic [4:0] DIM5  = 5'(BOARD_DIM);

    localparam logic [1:0] MSG_NONE = 2'b00;
    localparam logic [1:0] MSG_MISS = 2'b01;
    localparam logic [1:0] MSG_HIT  = 2'b10;
    localparam logic [1:0] MSG_SUNK = 2'b11;

    typedef enum logic [2:0] {IDLE, READ, EVAL, SEND, DONE} state_t;

    state_t           state_q, state_d;
    logic [7:0]       addr_q;
    logic [CELLS-1:0] bitmap;
    logic [IW-1:0]    idx;
    logic             accept;
    logic             shot_oor;

    // Out-of-range shots skip the map read and are answered as a miss.
    assign shot_oor = ({1'b0, bus.shot_addr[7:4]} >= DIM5) ||
                      ({1'b0, bus.shot_addr[3:0]} >= DIM5);

    // Linear cell index; the maximum (CELLS-1) fits in IW bits, so the
    // narrower arithmetic gives the same result as an 8-bit computation.
    assign idx = IW'(addr_q[7:4]) * IW'(BOARD_DIM) + IW'(addr_q[3:0]);

    assign bus.shot_ready = (state_q == IDLE) && armed && !game_over;
    assign accept         = bus.shot_valid && bus.shot_ready;
    assign bus.ship_addr  = addr_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; new_game overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = shot_oor ? SEND : READ;
            READ:    state_d = EVAL;
            EVAL:    state_d = SEND;
            SEND:    if (bus.msg_ready) state_d = game_over ? DONE : IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (new_game) state_d = IDLE;
    end

    // Strobes follow the state being entered so they are registered
    // and line up exactly with READ and SEND.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ship_rd   <= 1'b0;
            bus.msg_valid <= 1'b0;
        end else begin
            bus.ship_rd   <= (state_d == READ);
            bus.msg_valid <= (state_d == SEND);
        end
    end

    // Game datapath: shot latch, hit bitmap, cell counter and result code.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q     <= 8'h00;
            bitmap     <= '0;
            cells_left <= 7'(SHIP_CELLS);
            game_over  <= 1'b0;
            bus.msg_out <= MSG_NONE;
        end else if (new_game) begin
            bitmap      <= '0;
            cells_left  <= 7'(SHIP_CELLS);
            game_over   <= 1'b0;
            bus.msg_out <= MSG_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q <= bus.shot_addr;
                        if (shot_oor) bus.msg_out <= MSG_MISS;
                    end
                end
                EVAL: begin
                    if (!bus.ship_data) begin
                        bus.msg_out <= MSG_MISS;
                    end else if (bitmap[idx]) begin
                        bus.msg_out <= MSG_HIT;
                    end else begin
                        bitmap[idx] <= 1'b1;
                        // Counter saturates at zero; reaching zero sinks the fleet.
                        if (cells_left <= 7'd1) begin
                            cells_left  <= 7'd0;
                            game_over   <= 1'b1;
                            bus.msg_out <= MSG_SUNK;
                        end else begin
                            cells_left  <= cells_left - 7'd1;
                            bus.msg_out <= MSG_HIT;
                        end
                    end
                end
                SEND: if (bus.msg_ready) bus.msg_out <= MSG_NONE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shot_responder.sv
// Self-checking bench for shot_responder: directed scenarios followed by
// randomized shots, checked against a board-level game model.
module tb_shot_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       armed = 1'b0;
    logic       new_game = 1'b0;
    logic [6:0] cells_left;
    logic       game_over;

    shot_responder_if bus();

    shot_responder #(.BOARD_DIM(10), .SHIP_CELLS(11)) dut (
        .clk(clk), .rst(rst), .armed(armed), .new_game(new_game),
        .bus(bus), .cells_left(cells_left), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Board model: ship placement and cells already struck, by address.
    bit         ship_map[256];
    bit         hit_map[256];
    logic [7:0] ships[$];
    int         left;
    bit         over;
    int         passed = 0;
    int         total  = 0;

    // Ship-map memory: one-cycle read latency.
    always @(posedge clk) bus.ship_data <= bus.ship_rd ? ship_map[bus.ship_addr] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit on_board(input logic [7:0] a);
        int r = int'(a[7:4]);
        int c = int'(a[3:0]);
        return (r < 10) && (c < 10);
    endfunction

    function automatic int model_shot(input logic [7:0] a);
        if (!on_board(a) || !ship_map[a]) return 1;
        if (hit_map[a]) return 2;
        hit_map[a] = 1'b1;
        left = left - 1;
        if (left == 0) begin
            over = 1'b1;
            return 3;
        end
        return 2;
    endfunction

    function automatic void model_new();
        foreach (hit_map[i]) hit_map[i] = 1'b0;
        left = 11;
        over = 1'b0;
    endfunction

    task automatic pulse_new_game();
        @(negedge clk) new_game = 1'b1;
        @(negedge clk) new_game = 1'b0;
        model_new();
    endtask

    // One complete shot exchange with bp cycles of backpressure after msg_valid.
    task automatic fire(input logic [7:0] a, input int bp);
        int         lat, n, exp;
        bit         saw_rd, stable, inr;
        logic [7:0] rd_addr;
        inr = on_board(a);
        exp = model_shot(a);
        @(negedge clk);
        bus.msg_ready  = (bp == 0);
        bus.shot_valid = 1'b1;
        bus.shot_addr  = a;
        n = 0;
        while (!bus.shot_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("shot_ready", bus.shot_ready, 1);
        @(posedge clk);
        lat = 0; saw_rd = 0; rd_addr = 8'h00;
        do begin
            @(negedge clk);
            bus.shot_valid = 1'b0;
            lat++;
            if (bus.ship_rd) begin
                saw_rd  = 1'b1;
                rd_addr = bus.ship_addr;
            end
        end while (!bus.msg_valid && lat < 20);
        chk("latency", lat, inr ? 3 : 1);
        chk("ship_rd", saw_rd, inr);
        if (inr) chk("ship_addr", rd_addr, a);
        chk("msg_out", bus.msg_out, exp);
        chk("cells_left", cells_left, left);
        chk("game_over", game_over, over);
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!bus.msg_valid || bus.msg_out !== 2'(exp) || bus.ship_rd) stable = 1'b0;
        end
        if (bp > 0) chk("hold_stable", stable, 1);
        bus.msg_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("msg_drop", {bus.msg_valid, bus.msg_out}, 0);
        chk("ready_after", bus.shot_ready, !over);
    endtask

    initial begin
        int   saw;
        logic [7:0] a;
        bus.shot_valid = 1'b0;
        bus.shot_addr  = 8'h00;
        bus.msg_ready  = 1'b1;

        // Ship layout: 0x23 first, 10 more distinct on-board cells, never 0x45.
        ships.push_back(8'h23);
        ship_map[8'h23] = 1'b1;
        while (ships.size() < 11) begin
            a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            if (!ship_map[a] && a != 8'h45) begin
                ship_map[a] = 1'b1;
                ships.push_back(a);
            end
        end
        model_new();

        // Reset with armed low.
        repeat (2) @(negedge clk);
        chk("rst_shot_ready", bus.shot_ready, 0);
        chk("rst_msg_valid", bus.msg_valid, 0);
        chk("rst_msg_out", bus.msg_out, 0);
        chk("rst_ship_rd", bus.ship_rd, 0);
        chk("rst_ship_addr", bus.ship_addr, 0);
        chk("rst_cells_left", cells_left, 11);
        chk("rst_game_over", game_over, 0);
        rst = 1'b1;
        armed = 1'b1;
        #1 chk("armed_ready", bus.shot_ready, 1);

        // Miss, hit, repeat hit.
        fire(8'h45, 0);
        fire(8'h23, 0);
        fire(8'h23, 0);

        // Sink the fleet; 0x23 is a repeat, the last fresh cell sinks it.
        foreach (ships[i]) fire(ships[i], 0);
        chk("sunk_over", game_over, 1);
        chk("sunk_cells", cells_left, 0);

        // Shots are ignored once the game is over.
        @(negedge clk);
        bus.shot_valid = 1'b1;
        bus.shot_addr  = ships[1];
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.shot_ready || bus.msg_valid || bus.ship_rd) saw++;
        end
        bus.shot_valid = 1'b0;
        chk("done_ignore", saw, 0);
        pulse_new_game();
        chk("ng_cells", cells_left, 11);
        chk("ng_over", game_over, 0);
        chk("ng_ready", bus.shot_ready, 1);

        // Out-of-range shot under long backpressure.
        fire(8'hA3, 20);

        // Disarming only blocks acceptance.
        @(negedge clk) armed = 1'b0;
        #1 chk("disarm_ready", bus.shot_ready, 0);
        @(negedge clk) armed = 1'b1;

        // Abort a pending hit message with new_game.
        fire(8'h23, 0);
        @(negedge clk);
        bus.msg_ready  = 1'b0;
        bus.shot_valid = 1'b1;
        bus.shot_addr  = ships[2];
        @(posedge clk);
        repeat (3) @(negedge clk) bus.shot_valid = 1'b0;
        chk("abort_pending", bus.msg_valid, 1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_new();
        chk("abort_drop", {bus.msg_valid, bus.msg_out}, 0);
        chk("abort_cells", cells_left, 11);
        bus.msg_ready = 1'b1;
        fire(8'h23, 0);

        // Randomized shots against the model.
        for (int k = 0; k < 40; k++) begin
            int sel;
            if (over) pulse_new_game();
            sel = int'($urandom_range(0, 3));
            if (sel < 2)       a = ships[$urandom_range(0, 10)];
            else if (sel == 2) a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else               a = 8'($urandom);
            fire(a, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
